// File: rtl/tl_track_pkg.sv
// tl_track_pkg: shared TileLink-UL opcode constants and the per-source
// entry record used by tl_source_tracker.
package tl_track_pkg;

  localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET        = 3'd4;
  localparam logic [2:0] TL_D_ACK        = 3'd0;
  localparam logic [2:0] TL_D_ACKDATA    = 3'd1;

  typedef struct packed {
    logic       valid;
    logic       is_get;
    logic [2:0] size;
  } tl_track_entry_t;

endpackage

// File: rtl/tl_source_tracker_if.sv
// tl_source_tracker_if: TileLink-UL A and D channel signals.
//   master  : drives A request and d_ready
//   slave   : drives a_ready and D response
//   monitor : observes everything (used by tl_source_tracker)
interface tl_source_tracker_if #(
  parameter int unsigned SOURCE_W = 4
);
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [SOURCE_W-1:0] a_source;
  logic [2:0]          a_size;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [SOURCE_W-1:0] d_source;
  logic [2:0]          d_size;

  modport master (
    output a_valid, a_opcode, a_source, a_size, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_size
  );

  modport slave (
    input  a_valid, a_opcode, a_source, a_size, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_size
  );

  modport monitor (
    input a_valid, a_ready, a_opcode, a_source, a_size,
          d_valid, d_ready, d_opcode, d_source, d_size
  );
endinterface

// File: rtl/tl_track_watchdog.sv
// tl_track_watchdog: 16-bit saturating idle counter for tl_source_tracker.
//   clock, reset_n : clock, async active-low reset
//   clear          : restart counting (nothing in flight or a response retired)
//   expire         : high during the cycle the counter sits at TIMEOUT-1
// Only instantiated when TL_TRACK_TIMEOUT_EN is defined.
module tl_track_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic expire
);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    expire = 1'b0;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      expire = 1'b1;
      cnt_d  = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tl_source_tracker.sv
// tl_source_tracker: per-source in-flight tracker for a TileLink-UL link.
// Observes A/D fires and reports protocol violations as registered pulses.
//   clock, reset_n  : clock, async active-low reset
//   bus             : A/D channel signals (monitor modport, never driven)
//   err_a_opcode    : A fired with opcode outside {PutFull, PutPartial, Get}
//   err_dup_source  : A fired on a source already in flight
//   err_unexp_d     : D fired on a source not in flight
//   err_d_opcode    : D opcode does not match stored request class
//   err_d_size      : d_size differs from stored a_size
//   err_timeout     : watchdog expired (0 unless TL_TRACK_TIMEOUT_EN)
//   err_sticky      : OR of all error pulses since reset
//   inflight_cnt    : number of valid entries
// Optional feature macro: TL_TRACK_TIMEOUT_EN (watchdog present).
module tl_source_tracker
  import tl_track_pkg::*;
#(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  tl_source_tracker_if.monitor bus,
  output logic                err_a_opcode,
  output logic                err_dup_source,
  output logic                err_unexp_d,
  output logic                err_d_opcode,
  output logic                err_d_size,
  output logic                err_timeout,
  output logic                err_sticky,
  output logic [SOURCE_W:0]   inflight_cnt
);
  localparam int unsigned N = 2 ** SOURCE_W;

  tl_track_entry_t entry_q [N];
  tl_track_entry_t entry_d [N];
  logic [SOURCE_W:0] cnt_q, cnt_d;
  logic [6:0] err_q, err_d;   // {a_op, dup, unexp, d_op, d_size, timeout, sticky}

  logic a_fire, d_fire, a_legal, a_ok, d_hit, retire_same, alloc_new;
  logic wd_expire;
  tl_track_entry_t d_ent, a_ent;

  always_comb begin
    a_fire      = bus.a_valid & bus.a_ready;
    d_fire      = bus.d_valid & bus.d_ready;
    a_legal     = (bus.a_opcode == TL_A_PUTFULL) | (bus.a_opcode == TL_A_PUTPARTIAL) |
                  (bus.a_opcode == TL_A_GET);
    a_ok        = a_fire & a_legal;
    d_ent       = entry_q[bus.d_source];
    a_ent       = entry_q[bus.a_source];
    d_hit       = d_fire & d_ent.valid;
    retire_same = d_hit & (bus.d_source == bus.a_source);
    // A new allocation grows the count; overwriting a live entry does not.
    alloc_new   = a_ok & (~a_ent.valid | retire_same);

    for (int unsigned i = 0; i < N; i++) entry_d[i] = entry_q[i];
    // D retires first so a same-source A in the same cycle lands on a free slot.
    if (d_hit) entry_d[bus.d_source] = '0;
    if (a_ok) begin
      entry_d[bus.a_source].valid  = 1'b1;
      entry_d[bus.a_source].is_get = (bus.a_opcode == TL_A_GET);
      entry_d[bus.a_source].size   = bus.a_size;
    end

    cnt_d = cnt_q + {{SOURCE_W{1'b0}}, alloc_new} - {{SOURCE_W{1'b0}}, d_hit};

    err_d[6] = a_fire & ~a_legal;
    err_d[5] = a_ok & a_ent.valid & ~retire_same;
    err_d[4] = d_fire & ~d_ent.valid;
    err_d[3] = d_hit & (d_ent.is_get ? (bus.d_opcode != TL_D_ACKDATA)
                                     : (bus.d_opcode != TL_D_ACK));
    err_d[2] = d_hit & (bus.d_size != d_ent.size);
    err_d[1] = wd_expire;
    err_d[0] = err_q[0] | (|err_d[6:1]);
  end

`ifdef TL_TRACK_TIMEOUT_EN
  tl_track_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((cnt_q == '0) | d_hit),
    .expire  (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) entry_q[i] <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) entry_q[i] <= entry_d[i];
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_a_opcode   = err_q[6];
  assign err_dup_source = err_q[5];
  assign err_unexp_d    = err_q[4];
  assign err_d_opcode   = err_q[3];
  assign err_d_size     = err_q[2];
  assign err_timeout    = err_q[1];
  assign err_sticky     = err_q[0];
  assign inflight_cnt   = cnt_q;
endmodule

// File: tb/tb_tl_source_tracker.sv
module tb_tl_source_tracker;
  localparam int unsigned SW  = 4;
  localparam int unsigned NS  = 16;
  localparam int unsigned TMO = 16;
`ifdef TL_TRACK_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tl_source_tracker_if #(.SOURCE_W(SW)) bus ();

  logic e_aop, e_dup, e_unexp, e_dop, e_dsz, e_tmo, e_sticky;
  logic [SW:0] cnt;

  tl_source_tracker #(.SOURCE_W(SW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .err_a_opcode(e_aop), .err_dup_source(e_dup), .err_unexp_d(e_unexp),
    .err_d_opcode(e_dop), .err_d_size(e_dsz), .err_timeout(e_tmo),
    .err_sticky(e_sticky), .inflight_cnt(cnt)
  );

  // Reference model: what each source currently has outstanding.
  bit       m_valid [NS];
  bit       m_get   [NS];
  int       m_size  [NS];
  bit       m_sticky;
  int       m_age;
  int       n_tests = 0;
  int       n_fail  = 0;

  function automatic int live_count();
    int c = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_get[i] = 0; m_size[i] = 0;
    end
    m_sticky = 0;
    m_age    = 0;
  endtask

  task automatic check(string tag, logic [6:0] exp_err, int exp_cnt);
    logic [6:0] got;
    got = {e_aop, e_dup, e_unexp, e_dop, e_dsz, e_tmo, e_sticky};
    n_tests++;
    assert (got === exp_err) else begin
      n_fail++;
      $error("FAIL %s errs got=%b want=%b", tag, got, exp_err);
    end
    n_tests++;
    assert (cnt === (SW+1)'(exp_cnt)) else begin
      n_fail++;
      $error("FAIL %s inflight_cnt got=%0d want=%0d", tag, cnt, exp_cnt);
    end
  endtask

  task automatic idle_bus();
    bus.a_valid = 0; bus.a_ready = 0; bus.a_opcode = 0; bus.a_source = 0; bus.a_size = 0;
    bus.d_valid = 0; bus.d_ready = 0; bus.d_opcode = 0; bus.d_source = 0; bus.d_size = 0;
  endtask

  // One clock: drive at negedge, predict, check 1 time unit after posedge.
  task automatic step(string tag, bit af, int aop, int asrc, int asz,
                      bit df, int dop, int dsrc, int dsz);
    bit x_aop, x_dup, x_unexp, x_dop, x_dsz, x_tmo, legal, dhit, wd_clr;
    @(negedge clock);
    bus.a_valid = af; bus.a_ready = af | ($urandom_range(0, 1) == 1);
    if (!af) bus.a_valid = 0;
    bus.a_opcode = 3'(aop); bus.a_source = SW'(asrc); bus.a_size = 3'(asz);
    bus.d_valid = df; bus.d_ready = df | ($urandom_range(0, 1) == 1);
    bus.d_opcode = 3'(dop); bus.d_source = SW'(dsrc); bus.d_size = 3'(dsz);

    legal   = (aop == 0) || (aop == 1) || (aop == 4);
    dhit    = df && m_valid[dsrc];
    x_unexp = df && !m_valid[dsrc];
    x_dop   = dhit && (m_get[dsrc] ? (dop != 1) : (dop != 0));
    x_dsz   = dhit && (dsz != m_size[dsrc]);
    x_aop   = af && !legal;
    x_dup   = af && legal && m_valid[asrc] && !(dhit && dsrc == asrc);

    wd_clr = (live_count() == 0) || dhit;
    x_tmo  = WD_EN && !wd_clr && (m_age == TMO - 1);
    if (wd_clr || x_tmo) m_age = 0;
    else if (m_age < 65535) m_age++;

    if (dhit) m_valid[dsrc] = 0;
    if (af && legal) begin
      m_valid[asrc] = 1; m_get[asrc] = (aop == 4); m_size[asrc] = asz;
    end
    m_sticky = m_sticky | x_aop | x_dup | x_unexp | x_dop | x_dsz | x_tmo;

    @(posedge clock);
    #1;
    check(tag, {x_aop, x_dup, x_unexp, x_dop, x_dsz, x_tmo, m_sticky}, live_count());
  endtask

  task automatic nop(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset(string tag);
    @(negedge clock);
    #2 reset_n = 0;
    idle_bus();
    model_reset();
    #1;
    check(tag, '0, 0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    idle_bus();
    model_reset();
    #12;
    check("reset", '0, 0);
    @(negedge clock);
    reset_n = 1;

    // Get/AccessAckData round trip on source 3.
    step("get3",       1, 4, 3, 2, 0, 0, 0, 0);
    step("ackdata3",   0, 0, 0, 0, 1, 1, 3, 2);
    // PutFull answered with AccessAckData -> opcode error.
    step("put5",       1, 0, 5, 3, 0, 0, 0, 0);
    step("baddop5",    0, 0, 0, 0, 1, 1, 5, 3);
    nop("pulse_end");
    // Duplicate Get on source 7.
    step("get7a",      1, 4, 7, 1, 0, 0, 0, 0);
    step("get7b_dup",  1, 4, 7, 1, 0, 0, 0, 0);
    step("ack7",       0, 0, 0, 0, 1, 1, 7, 1);
    // Unexpected response.
    step("unexp2",     0, 0, 0, 0, 1, 0, 2, 0);
    // Size mismatch and illegal opcode together with a legal put.
    step("pp9",        1, 1, 9, 0, 0, 0, 0, 0);
    step("badsz9",     1, 6, 4, 0, 1, 0, 9, 5);
    // Same-cycle retire and reallocate on source 1.
    step("get1",       1, 4, 1, 3, 0, 0, 0, 0);
    step("swap1",      1, 4, 1, 3, 1, 1, 1, 3);
    step("ack1",       0, 0, 0, 0, 1, 1, 1, 3);

    // Watchdog: Get on source 0 and never answer.
    apply_reset("reset2");
    step("get0",       1, 4, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) nop("wd_wait");
    // Reset in the middle of a pending wait, then a stale response.
    step("get0b",      1, 4, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) nop("wd_wait2");
    apply_reset("reset_mid");
    step("stale0",     0, 0, 0, 0, 1, 1, 0, 2);

    // Randomized traffic over a few sources to provoke collisions.
    apply_reset("reset3");
    for (int i = 0; i < 600; i++) begin
      int aop_r, dsrc_r, dop_r, dsz_r;
      aop_r  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7))
                                            : (($urandom_range(0, 1) == 1) ? 4 : int'($urandom_range(0, 1)));
      dsrc_r = $urandom_range(0, 3);
      dop_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7))
                                            : (m_get[dsrc_r] ? 1 : 0);
      dsz_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : m_size[dsrc_r];
      step("rand", $urandom_range(0, 2) == 0, aop_r, $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom_range(0, 3) == 0, dop_r, dsrc_r, dsz_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
